quad_encoder_feedback: RTL

Quadrature encoder front end that produces the feedback side of the motor PID loop. It turns raw A/B encoder lines into a signed 32-bit position, a signed 16-bit velocity (counts per update window) and a periodic update_controller strobe. The PID controller consumes the strobe on its rising edge. Sits between the motor board encoder pins and the controller's position/velocity/update_controller inputs.

---
 rtl/quad_encoder_feedback_if.sv | 29 ++
 rtl/quad_encoder_feedback.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/quad_encoder_feedback_if.sv
// Encoder pins, control inputs and PID feedback outputs of quad_encoder_feedback.
// Optional: ENC_INDEX_EN adds the enc_index pin.
interface quad_encoder_feedback_if #(
  parameter int ERR_WIDTH = 8
);
  logic                 enc_a;
  logic                 enc_b;
`ifdef ENC_INDEX_EN
  logic                 enc_index;
`endif
  logic                 invert;
  logic                 zero;
  logic [31:0]          position;
  logic [15:0]          velocity;
  logic                 update_controller;
  logic [ERR_WIDTH-1:0] error_count;

`ifdef ENC_INDEX_EN
  modport master (output enc_a, enc_b, enc_index, invert, zero,
                  input  position, velocity, update_controller, error_count);
  modport slave  (input  enc_a, enc_b, enc_index, invert, zero,
                  output position, velocity, update_controller, error_count);
`else
  modport master (output enc_a, enc_b, invert, zero,
                  input  position, velocity, update_controller, error_count);
  modport slave  (input  enc_a, enc_b, invert, zero,
                  output position, velocity, update_controller, error_count);
`endif
endinterface

// File: rtl/quad_encoder_feedback.sv
// Quadrature decoder producing windowed position/velocity snapshots for the PID loop.
// Optional: ENC_INDEX_EN adds a filtered index input that clears the position accumulator.
module quad_encoder_feedback #(
  parameter int FILTER_LEN = 4,
  parameter int UPDATE_DIV = 50000,
  parameter int ERR_WIDTH  = 8
) (
  input logic                    clock,
  input logic                    reset,
  quad_encoder_feedback_if.slave bus
);
`ifdef ENC_INDEX_EN
  localparam int unsigned NCH = 3;
`else
  localparam int unsigned NCH = 2;
`endif
  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int WCW = $clog2(UPDATE_DIV);

  logic [NCH-1:0]       raw;
  logic [NCH-1:0]       sync1;
  logic [NCH-1:0]       sync2;
  logic [NCH-1:0]       last_smp;
  logic [NCH-1:0]       lvl;
  logic [NCH-1:0]       lvl_n;
  logic [FCW-1:0]       run   [NCH];
  logic [FCW-1:0]       run_n [NCH];
  logic [1:0]           vld;
  logic [1:0]           vld_n;
  logic                 primed;
  logic                 idx_edge;
  logic                 illegal;
  logic signed [31:0]   step;
  logic signed [31:0]   acc;
  logic signed [31:0]   acc_n;
  logic signed [31:0]   delta;
  logic signed [31:0]   delta_n;
  logic signed [15:0]   vel_sat;
  logic [WCW-1:0]       win;
  logic                 terminal;
  logic [31:0]          pos_q;
  logic [15:0]          vel_q;
  logic                 upd_q;
  logic [ERR_WIDTH-1:0] err_q;

`ifdef ENC_INDEX_EN
  assign raw      = {bus.enc_index, bus.enc_b, bus.enc_a};
  assign idx_edge = ~lvl[2] & lvl_n[2];
`else
  assign raw      = {bus.enc_b, bus.enc_a};
  assign idx_edge = 1'b0;
`endif

  function automatic logic [1:0] fwd_next(input logic [1:0] s);
    case (s)
      2'b00:   fwd_next = 2'b01;
      2'b01:   fwd_next = 2'b11;
      2'b11:   fwd_next = 2'b10;
      default: fwd_next = 2'b00;
    endcase
  endfunction

  // run counts consecutive equal synchronized samples, saturating at FILTER_LEN;
  // the level is accepted in the same cycle the run completes.
  always_comb begin : filter
    run_n = run;
    lvl_n = lvl;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (sync2[i] != last_smp[i])
        run_n[i] = FCW'(1);
      else if (run[i] != FCW'(FILTER_LEN))
        run_n[i] = run[i] + 1'b1;
      if (run_n[i] == FCW'(FILTER_LEN))
        lvl_n[i] = sync2[i];
    end
    vld_n = vld | {run_n[1] == FCW'(FILTER_LEN), run_n[0] == FCW'(FILTER_LEN)};
  end

  always_comb begin : decode
    step    = '0;
    illegal = 1'b0;
    if (primed) begin
      if (lvl_n[1:0] == fwd_next(lvl[1:0]))
        step = 32'sd1;
      else if (lvl[1:0] == fwd_next(lvl_n[1:0]))
        step = -32'sd1;
      else if (lvl_n[1:0] != lvl[1:0])
        illegal = 1'b1;
    end
    if (bus.invert)
      step = -step;
    delta_n = delta + step;
    acc_n   = (bus.zero || idx_edge) ? '0 : acc + step;
    if (delta_n > 32'sd32767)
      vel_sat = 16'sh7fff;
    else if (delta_n < -32'sd32768)
      vel_sat = 16'sh8000;
    else
      vel_sat = delta_n[15:0];
  end

  assign terminal = (win == WCW'(UPDATE_DIV - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1    <= '0;
      sync2    <= '0;
      last_smp <= '0;
      run      <= '{default: '0};
      lvl      <= '0;
      vld      <= '0;
      primed   <= 1'b0;
      acc      <= '0;
      delta    <= '0;
      win      <= '0;
      pos_q    <= '0;
      vel_q    <= '0;
      upd_q    <= 1'b0;
      err_q    <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      last_smp <= sync2;
      run      <= run_n;
      lvl      <= lvl_n;
      vld      <= vld_n;
      if (!primed && (&vld_n))
        primed <= 1'b1;
      acc <= acc_n;
      if (illegal && (err_q != '1))
        err_q <= err_q + 1'b1;
      upd_q <= terminal;
      if (terminal) begin
        win   <= '0;
        pos_q <= acc_n;
        vel_q <= vel_sat;
        delta <= '0;
      end else begin
        win   <= win + 1'b1;
        delta <= delta_n;
      end
    end
  end

  assign bus.position          = pos_q;
  assign bus.velocity          = vel_q;
  assign bus.update_controller = upd_q;
  assign bus.error_count       = err_q;
endmodule
